fifo_stream_reader: RTL and testbench

- Read-side consumer for the synchronous FIFO: drives the FIFO's rd_en and takes data_out, empty and underflow from it.
- Presents the read data as a valid/ready output stream through a 2-entry skid buffer.
- Sustains one word per cycle while the downstream is ready.
- Also counts delivered beats and flags FIFO protocol errors.

---
 rtl/fifo_stream_reader.sv | 100 ++++++++++
 tb/tb_fifo_stream_reader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side consumer for a synchronous FIFO: issues rd_en, lands read data into a
// 2-entry skid buffer and presents it as a valid/ready stream with a beat counter.
module fifo_stream_reader #(
   parameter int FIFO_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_rd_en,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  rd_count,
   output logic                  underflow_seen,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t                state, state_n;
   logic [1:0]            occ, occ_n;
   logic                  inflight;
   logic [FIFO_WIDTH-1:0] entry0, entry1, entry0_n, entry1_n;
   logic                  pop, push, discard, room;

   assign m_valid = (occ != 2'd0);
   assign m_data  = entry0;
   assign pop     = m_valid && m_ready;
   assign push    = inflight && !fifo_underflow;
   assign discard = inflight && fifo_underflow;
   assign busy    = m_valid || inflight;

   // A pop this cycle frees a slot, so m_ready feeds rd_en for back-to-back streaming.
   assign room       = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
   assign fifo_rd_en = rst_n && (state == RUN) && !fifo_empty && room;

   // NOTE: combinational blocks use blocking '=' and assign every output a default
   // first, so each path is fully specified and no latch is inferred.
   always_comb begin
      entry0_n = entry0;
      entry1_n = entry1;
      occ_n    = occ;
      if (pop) begin
         entry0_n = entry1;
         occ_n    = occ - 2'd1;
      end
      if (push) begin
         if (occ_n == 2'd0) entry0_n = fifo_data_out;
         else               entry1_n = fifo_data_out;
         occ_n = occ_n + 2'd1;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (enable) state_n = RUN;
         RUN:   if (!enable) state_n = (m_valid || inflight) ? DRAIN : IDLE;
         DRAIN: begin
            // No read is issued in DRAIN, so nothing new is in flight next cycle.
            if (enable)              state_n = RUN;
            else if (occ_n == 2'd0)  state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking '<=' so all registers update together
   // at the clock edge regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         occ            <= 2'd0;
         inflight       <= 1'b0;
         // NOTE: the buffer entries are reset because entry0 drives m_data, which
         // must read zero out of reset; the two entries cost little to clear.
         entry0         <= '0;
         entry1         <= '0;
         rd_count       <= '0;
         underflow_seen <= 1'b0;
      end else begin
         state    <= state_n;
         occ      <= occ_n;
         inflight <= fifo_rd_en;
         entry0   <= entry0_n;
         entry1   <= entry1_n;
         if (pop)     rd_count <= rd_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         if (discard) underflow_seen <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: behavioural FIFO, expected-word queue
// filled by the stimulus and drained by an independent output monitor.
module tb_fifo_stream_reader;

   localparam int W  = 16;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          m_ready = 1'b0;
   logic          fifo_empty, fifo_underflow, fifo_rd_en, m_valid, underflow_seen, busy;
   logic [W-1:0]  fifo_data_out, m_data;
   logic [CW-1:0] rd_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fifo_stream_reader #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow), .fifo_data_out(fifo_data_out),
      .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .rd_count(rd_count), .underflow_seen(underflow_seen), .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural FIFO: registered read data and underflow, empty flag updated at the edge.
   logic [W-1:0] fifo_q[$];
   logic [W-1:0] exp_q[$];
   int           fifo_cnt;
   bit           inject_aa = 1'b0;

   assign fifo_empty = (fifo_cnt == 0);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_data_out  <= '0;
         fifo_underflow <= 1'b0;
         fifo_cnt       <= fifo_q.size();
      end else begin
         fifo_underflow <= 1'b0;
         if (fifo_rd_en) begin
            if (fifo_cnt == 0) begin
               fifo_underflow <= 1'b1;
            end else begin
               automatic logic [W-1:0] w = fifo_q.pop_front();
               fifo_data_out <= w;
               if (inject_aa && w == 16'h00AA) fifo_underflow <= 1'b1;
            end
         end
         fifo_cnt <= fifo_q.size();
      end
   end

   // Output monitor: every handshake must match the next expected word, and the
   // beat counter must equal the number of handshakes seen, modulo 2^CW.
   int model_cnt = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         model_cnt = 0;
      end else begin
         check("rd_count", 32'(rd_count), 32'(model_cnt % (1 << CW)));
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_beat: got 0x%0h expected no beat at %0t", m_data, $time);
            end else begin
               check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
            model_cnt++;
         end
      end
   end

   task automatic load(input logic [W-1:0] w, input bit delivered);
      fifo_q.push_back(w);
      if (delivered) exp_q.push_back(w);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drained(input string name, input int budget);
      for (int k = 0; k < budget && (exp_q.size() != 0 || busy); k++) @(negedge clk);
      check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
      check({name, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [13:0] rd_bits, val_bits;
      int          pulses;

      // Reset held with data available and enable high.
      enable  = 1'b1;
      m_ready = 1'b1;
      for (int i = 1; i <= 8; i++) load(W'(i), 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_rd_count", 32'(rd_count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_underflow_seen", 32'(underflow_seen), 32'd0);
      rst_n = 1'b1;
      #1;
      check("idle_rd_en", 32'(fifo_rd_en), 32'd0);

      // Full-rate streaming: 8 reads back to back, data two cycles behind.
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         rd_bits[c]  = fifo_rd_en;
         val_bits[c] = m_valid;
      end
      check("stream_rd_en_pattern", 32'(rd_bits), 32'h00FF);
      check("stream_valid_pattern", 32'(val_bits), 32'h03FC);
      check("stream_rd_count", 32'(rd_count), 32'd8);

      // Backpressure: only two reads fit, head word held.
      step();
      m_ready = 1'b0;
      for (int i = 1; i <= 8; i++) load(W'(i), 1'b1);
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (fifo_rd_en) pulses++;
      end
      check("bp_rd_pulses", 32'(pulses), 32'd2);
      for (int c = 0; c < 3; c++) begin
         check("bp_m_valid", 32'(m_valid), 32'd1);
         check("bp_m_data_held", 32'(m_data), 32'h0001);
         @(negedge clk);
      end
      step();
      m_ready = 1'b1;
      wait_drained("bp", 40);

      // Enable drop with one word buffered and one in flight.
      step();
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) load(W'(16'h0041 + i), 1'b1);
      for (int k = 0; k < 10 && !fifo_rd_en; k++) @(negedge clk);
      check("drop_first_rd", 32'(fifo_rd_en), 32'd1);
      step();
      step();
      enable = 1'b0;
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (fifo_rd_en) pulses++;
      end
      check("drop_rd_pulses", 32'(pulses), 32'd0);
      check("drop_busy", 32'(busy), 32'd1);
      step();
      m_ready = 1'b1;
      for (int k = 0; k < 20 && busy; k++) @(negedge clk);
      check("drop_busy_fall", 32'(busy), 32'd0);
      check("drop_left_in_fifo", 32'(exp_q.size()), 32'd2);
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (fifo_rd_en) pulses++;
      end
      check("drop_idle_no_rd", 32'(pulses), 32'd0);

      // Underflow injected on the landing of 0x00AA: word dropped, flag sticky.
      step();
      enable    = 1'b1;
      inject_aa = 1'b1;
      load(16'h00A9, 1'b1);
      load(16'h00AA, 1'b0);
      load(16'h00AB, 1'b1);
      wait_drained("uf", 40);
      check("uf_seen", 32'(underflow_seen), 32'd1);
      inject_aa = 1'b0;

      // Randomized traffic with random enable and backpressure.
      for (int c = 0; c < 400; c++) begin
         step();
         enable  = ($urandom_range(0, 9) != 0);
         m_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) != 0 && fifo_q.size() < 20) load(W'($urandom), 1'b1);
      end
      step();
      enable  = 1'b1;
      m_ready = 1'b1;
      wait_drained("rand", 200);
      check("uf_sticky", 32'(underflow_seen), 32'd1);

      // Reset clears everything; then 17 beats wrap the 4-bit counter to 1.
      step();
      rst_n = 1'b0;
      fifo_q.delete();
      exp_q.delete();
      #1;
      check("rst2_underflow_seen", 32'(underflow_seen), 32'd0);
      check("rst2_rd_count", 32'(rd_count), 32'd0);
      check("rst2_busy", 32'(busy), 32'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 17; i++) load(W'(16'h0100 + i), 1'b1);
      wait_drained("wrap", 80);
      @(negedge clk);
      check("wrap_rd_count", 32'(rd_count), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
